// File: rtl/tpu_seq_control_if.sv
// Instruction handshake between the host issuing TPU instructions and the sequencer.
// The master presents instr/instr_valid and the slave returns instr_ready.
interface tpu_seq_control_if #(
  parameter int INSTR_W = 16
);
  logic [INSTR_W-1:0] instr;
  logic               instr_valid;
  logic               instr_ready;

  modport master (output instr, output instr_valid, input instr_ready);
  modport slave  (input instr, input instr_valid, output instr_ready);
endinterface

// File: rtl/tpu_seq_control.sv
// Mini TPU sequencer: decodes LOAD/STORE into one-cycle memory and array strobes, and
// runs a counter-driven compute phase that issues skewed per-lane operand reads.
module tpu_seq_control #(
  parameter  int N          = 4,
  parameter  int DATA_WIDTH = 8,
  parameter  int INSTR_W    = 16,
  localparam int IDX_W      = $clog2(N)
) (
  input  logic                  clk,
  input  logic                  rst,
  tpu_seq_control_if.slave      instr_if,
  output logic                  busy,
  output logic                  done,
  output logic                  array_clear,
  output logic                  array_write_enable,
  output logic [IDX_W-1:0]      array_output_row,
  output logic [IDX_W-1:0]      array_output_col,
  output logic                  array_output_valid,
  output logic [DATA_WIDTH-1:0] mema_data_in,
  output logic [DATA_WIDTH-1:0] memb_data_in,
  output logic                  mema_write_enable,
  output logic                  memb_write_enable,
  output logic [IDX_W-1:0]      mema_write_line,
  output logic [IDX_W-1:0]      mema_write_elem,
  output logic [IDX_W-1:0]      memb_write_line,
  output logic [IDX_W-1:0]      memb_write_elem,
  output logic [N-1:0]          mema_read_enable,
  output logic [N-1:0]          memb_read_enable,
  output logic [N*IDX_W-1:0]    mema_read_elem,
  output logic [N*IDX_W-1:0]    memb_read_elem
);

  localparam int CNT_W = $clog2(3 * N);
  localparam int LAST  = 3 * N - 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    OP_START = 2'b00,
    OP_STOP  = 2'b01,
    OP_LOAD  = 2'b10,
    OP_STORE = 2'b11
  } op_e;

  // Instruction fields
  op_e                   op;
  logic                  sel;
  logic [IDX_W-1:0]      row;
  logic [IDX_W-1:0]      col;
  logic [DATA_WIDTH-1:0] imm;
  logic                  unused_instr;

  assign op           = op_e'(instr_if.instr[INSTR_W-1 -: 2]);
  assign sel          = instr_if.instr[INSTR_W-3];
  assign row          = instr_if.instr[DATA_WIDTH+2*IDX_W-1 -: IDX_W];
  assign col          = instr_if.instr[DATA_WIDTH+IDX_W-1 -: IDX_W];
  assign imm          = instr_if.instr[DATA_WIDTH-1:0];
  assign unused_instr = ^instr_if.instr;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  clear_q, clear_d;
  logic                  mema_we_q, mema_we_d;
  logic                  memb_we_q, memb_we_d;
  logic [DATA_WIDTH-1:0] mema_data_q, mema_data_d;
  logic [DATA_WIDTH-1:0] memb_data_q, memb_data_d;
  logic [IDX_W-1:0]      mema_line_q, mema_line_d;
  logic [IDX_W-1:0]      mema_elem_q, mema_elem_d;
  logic [IDX_W-1:0]      memb_line_q, memb_line_d;
  logic [IDX_W-1:0]      memb_elem_q, memb_elem_d;
  logic [IDX_W-1:0]      out_row_q, out_row_d;
  logic [IDX_W-1:0]      out_col_q, out_col_d;
  logic                  out_valid_q, out_valid_d;

  logic                  ready;
  logic                  accept;
  logic [N-1:0]          rd_en;
  logic [N*IDX_W-1:0]    rd_elem;

  // NOTE: every signal written here gets a default first, so no path leaves a latch.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    clear_d     = 1'b0;
    mema_we_d   = 1'b0;
    memb_we_d   = 1'b0;
    out_valid_d = 1'b0;
    mema_data_d = mema_data_q;
    memb_data_d = memb_data_q;
    mema_line_d = mema_line_q;
    mema_elem_d = mema_elem_q;
    memb_line_d = memb_line_q;
    memb_elem_d = memb_elem_q;
    out_row_d   = out_row_q;
    out_col_d   = out_col_q;

    unique case (state_q)
      S_IDLE:  ready = 1'b1;
      S_RUN:   ready = (op == OP_STOP);
      default: ready = 1'b0;
    endcase
    accept = instr_if.instr_valid && ready;

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          unique case (op)
            OP_START: begin
              state_d = S_RUN;
              cnt_d   = '0;
              clear_d = ~imm[0];
            end
            OP_LOAD: begin
              if (!sel) begin
                mema_we_d   = 1'b1;
                mema_data_d = imm;
                mema_line_d = row;
                mema_elem_d = col;
              end else begin
                memb_we_d   = 1'b1;
                memb_data_d = imm;
                memb_line_d = col;
                memb_elem_d = row;
              end
            end
            OP_STORE: begin
              out_valid_d = 1'b1;
              out_row_d   = row;
              out_col_d   = col;
            end
            default: ;
          endcase
        end
      end
      S_RUN: begin
        cnt_d = cnt_q + 1'b1;
        if (accept) begin
          // Abort: back to IDLE without a done pulse
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(LAST)) begin
          state_d = S_DONE;
          cnt_d   = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Lane i is skewed by i+1 cycles so operands enter the array as a wavefront
  always_comb begin
    rd_en   = '0;
    rd_elem = '0;
    for (int i = 0; i < N; i++) begin
      if (state_q == S_RUN && cnt_q >= CNT_W'(i + 1) && cnt_q <= CNT_W'(i + N)) begin
        rd_en[i]                  = 1'b1;
        rd_elem[i*IDX_W +: IDX_W] = IDX_W'(cnt_q - CNT_W'(i + 1));
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      clear_q     <= 1'b0;
      mema_we_q   <= 1'b0;
      memb_we_q   <= 1'b0;
      mema_data_q <= '0;
      memb_data_q <= '0;
      mema_line_q <= '0;
      mema_elem_q <= '0;
      memb_line_q <= '0;
      memb_elem_q <= '0;
      out_row_q   <= '0;
      out_col_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      clear_q     <= clear_d;
      mema_we_q   <= mema_we_d;
      memb_we_q   <= memb_we_d;
      mema_data_q <= mema_data_d;
      memb_data_q <= memb_data_d;
      mema_line_q <= mema_line_d;
      mema_elem_q <= mema_elem_d;
      memb_line_q <= memb_line_d;
      memb_elem_q <= memb_elem_d;
      out_row_q   <= out_row_d;
      out_col_q   <= out_col_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign instr_if.instr_ready = ready;
  assign busy                 = (state_q == S_RUN);
  assign array_write_enable   = (state_q == S_RUN);
  assign done                 = (state_q == S_DONE);
  assign array_clear          = clear_q;
  assign array_output_row     = out_row_q;
  assign array_output_col     = out_col_q;
  assign array_output_valid   = out_valid_q;
  assign mema_data_in         = mema_data_q;
  assign memb_data_in         = memb_data_q;
  assign mema_write_enable    = mema_we_q;
  assign memb_write_enable    = memb_we_q;
  assign mema_write_line      = mema_line_q;
  assign mema_write_elem      = mema_elem_q;
  assign memb_write_line      = memb_line_q;
  assign memb_write_elem      = memb_elem_q;
  assign mema_read_enable     = rd_en;
  assign memb_read_enable     = rd_en;
  assign mema_read_elem       = rd_elem;
  assign memb_read_elem       = rd_elem;

endmodule

// File: tb/tb_tpu_seq_control.sv
// Self-checking bench for tpu_seq_control (N=4, 8-bit data, 16-bit instructions):
// directed scenarios with literal expectations, then random traffic against a cycle model.
module tb_tpu_seq_control;

  localparam int N     = 4;
  localparam int IDX_W = 2;
  localparam int DW    = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;

  tpu_seq_control_if #(.INSTR_W(16)) ifc ();

  logic              busy, done, array_clear, array_write_enable;
  logic [IDX_W-1:0]  out_row, out_col;
  logic              out_valid;
  logic [DW-1:0]     a_data, b_data;
  logic              a_we, b_we;
  logic [IDX_W-1:0]  a_line, a_elem, b_line, b_elem;
  logic [N-1:0]      a_ren, b_ren;
  logic [N*IDX_W-1:0] a_relem, b_relem;

  tpu_seq_control #(.N(N), .DATA_WIDTH(DW), .INSTR_W(16)) dut (
    .clk                (clk),
    .rst                (rst),
    .instr_if           (ifc.slave),
    .busy               (busy),
    .done               (done),
    .array_clear        (array_clear),
    .array_write_enable (array_write_enable),
    .array_output_row   (out_row),
    .array_output_col   (out_col),
    .array_output_valid (out_valid),
    .mema_data_in       (a_data),
    .memb_data_in       (b_data),
    .mema_write_enable  (a_we),
    .memb_write_enable  (b_we),
    .mema_write_line    (a_line),
    .mema_write_elem    (a_elem),
    .memb_write_line    (b_line),
    .memb_write_elem    (b_elem),
    .mema_read_enable   (a_ren),
    .memb_read_enable   (b_ren),
    .mema_read_elem     (a_relem),
    .memb_read_elem     (b_relem)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  bit        m_ok = 0;
  bit        m_running = 0;
  bit        m_done = 0;
  int        m_t = 0;      // cycles elapsed since compute start
  bit        e_clear, e_awe, e_bwe, e_oval;
  logic [7:0] e_adata, e_bdata;
  logic [1:0] e_aline, e_aelem, e_bline, e_belem, e_orow, e_ocol;
  logic [N-1:0]       en_exp;
  logic [N*IDX_W-1:0] elem_exp;

  function automatic bit m_ready(input logic [15:0] ins);
    if (m_done) return 1'b0;
    if (m_running) return ins[15:14] == 2'b01;
    return 1'b1;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_ok = 1; m_running = 0; m_done = 0; m_t = 0;
      e_clear = 0; e_awe = 0; e_bwe = 0; e_oval = 0;
      e_adata = 0; e_bdata = 0; e_aline = 0; e_aelem = 0;
      e_bline = 0; e_belem = 0; e_orow = 0; e_ocol = 0;
    end else begin
      bit acc;
      acc = ifc.instr_valid && m_ready(ifc.instr);
      e_clear = 0; e_awe = 0; e_bwe = 0; e_oval = 0;
      if (m_done) m_done = 0;
      else if (m_running) begin
        if (acc) m_running = 0;
        else if (m_t == 3 * N - 1) begin m_running = 0; m_done = 1; end
        else m_t++;
      end else if (acc) begin
        case (ifc.instr[15:14])
          2'b00: begin m_running = 1; m_t = 0; e_clear = !ifc.instr[0]; end
          2'b10: begin
            if (!ifc.instr[13]) begin
              e_awe = 1; e_adata = ifc.instr[7:0];
              e_aline = ifc.instr[11:10]; e_aelem = ifc.instr[9:8];
            end else begin
              e_bwe = 1; e_bdata = ifc.instr[7:0];
              e_bline = ifc.instr[9:8]; e_belem = ifc.instr[11:10];
            end
          end
          2'b11: begin e_oval = 1; e_orow = ifc.instr[11:10]; e_ocol = ifc.instr[9:8]; end
          default: ;
        endcase
      end
    end
  end

  always @(negedge clk) begin
    if (m_ok) begin
      for (int i = 0; i < N; i++) begin
        en_exp[i] = m_running && m_t >= i + 1 && m_t <= i + N;
        elem_exp[i*IDX_W +: IDX_W] = en_exp[i] ? IDX_W'(m_t - (i + 1)) : '0;
      end
      check("m_ready", 32'(ifc.instr_ready), 32'(m_ready(ifc.instr)));
      check("m_busy", 32'(busy), 32'(m_running));
      check("m_arr_we", 32'(array_write_enable), 32'(m_running));
      check("m_done", 32'(done), 32'(m_done));
      check("m_clear", 32'(array_clear), 32'(e_clear));
      check("m_a_we", 32'(a_we), 32'(e_awe));
      check("m_b_we", 32'(b_we), 32'(e_bwe));
      check("m_a_data", 32'(a_data), 32'(e_adata));
      check("m_b_data", 32'(b_data), 32'(e_bdata));
      check("m_a_addr", {a_line, a_elem}, {e_aline, e_aelem});
      check("m_b_addr", {b_line, b_elem}, {e_bline, e_belem});
      check("m_out_valid", 32'(out_valid), 32'(e_oval));
      check("m_out_rc", {out_row, out_col}, {e_orow, e_ocol});
      check("m_a_ren", 32'(a_ren), 32'(en_exp));
      check("m_b_ren", 32'(b_ren), 32'(en_exp));
      check("m_a_relem", 32'(a_relem), 32'(elem_exp));
      check("m_b_relem", 32'(b_relem), 32'(elem_exp));
    end
  end

  // ---------------- stimulus ----------------
  task automatic nxt();
    @(posedge clk); #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic send(input logic [15:0] ins);
    ifc.instr = ins; ifc.instr_valid = 1'b1;
    nxt();
    ifc.instr_valid = 1'b0;
  endtask

  initial begin
    ifc.instr = '0; ifc.instr_valid = 1'b0;
    nxt(); mid();
    check("rst_ready", 32'(ifc.instr_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ren", 32'(a_ren), 32'd0);
    check("rst_we", {a_we, b_we, out_valid, done}, 32'd0);
    nxt(); rst = 1'b0; nxt();

    // LOAD A
    send(16'h865A); mid();
    check("lda_we", {a_we, b_we}, 32'b10);
    check("lda_data", 32'(a_data), 32'h5A);
    check("lda_addr", {a_line, a_elem}, {2'd1, 2'd2});
    mid();
    check("lda_we_off", 32'(a_we), 32'd0);
    nxt();

    // LOAD B (transposed)
    send(16'hACC3); mid();
    check("ldb_we", {a_we, b_we}, 32'b01);
    check("ldb_data", 32'(b_data), 32'hC3);
    check("ldb_addr", {b_line, b_elem}, {2'd0, 2'd3});
    nxt();

    // START, with a LOAD held valid through RUN
    send(16'h0000);
    ifc.instr = 16'h8107; ifc.instr_valid = 1'b1;
    for (int j = 1; j <= 14; j++) begin
      mid();
      if (j == 1) begin check("st_clear", 32'(array_clear), 32'd1); check("st_busy1", 32'(busy), 32'd1); end
      if (j == 1 || j == 13) check("st_stall", 32'(ifc.instr_ready), 32'd0);
      if (j == 2) begin check("st_clear_off", 32'(array_clear), 32'd0); check("st_ren1", 32'(a_ren), 32'b0001); end
      if (j == 5) check("st_ren4", 32'(a_ren), 32'b1111);
      if (j >= 5 && j <= 8) check("st_lane3", 32'(a_relem[7:6]), 32'(j - 5));
      if (j == 12) check("st_busy12", {busy, done}, 32'b10);
      if (j == 13) check("st_done", {busy, done}, 32'b01);
      if (j == 14) check("st_ready14", {ifc.instr_ready, done}, 32'b10);
      nxt();
    end
    ifc.instr_valid = 1'b0;
    mid();
    check("st_held_ld", {a_we, a_data}, {1'b1, 8'h07});
    nxt();

    // START accumulate, STOP at cnt=5
    send(16'h0001);
    for (int j = 1; j <= 8; j++) begin
      mid();
      if (j == 1) check("acc_clear", {array_clear, busy}, 32'b01);
      if (j == 2) check("acc_ren1", 32'(a_ren), 32'b0001);
      if (j == 5) check("acc_ren4", 32'(a_ren), 32'b1111);
      if (j == 6) begin check("acc_stop_rdy", 32'(ifc.instr_ready), 32'd1); check("acc_ren5", 32'(a_ren), 32'b1110); end
      if (j == 7) check("acc_abort", {busy, done, a_ren, b_ren}, 32'd0);
      if (j == 8) check("acc_nodone", {done, ifc.instr_ready}, 32'b01);
      nxt();
      if (j == 5) begin ifc.instr = 16'h4000; ifc.instr_valid = 1'b1; end
      if (j == 6) ifc.instr_valid = 1'b0;
    end

    // STORE
    send(16'hC900); mid();
    check("store", {out_valid, out_row, out_col}, {1'b1, 2'd2, 2'd1});
    nxt(); mid();
    check("store_hold", {out_valid, out_row, out_col}, {1'b0, 2'd2, 2'd1});
    nxt();

    // Reset mid-RUN at cnt=6
    send(16'h0000);
    for (int j = 1; j <= 16; j++) begin
      mid();
      if (j == 7) check("rr_ren6", {busy, a_ren}, {1'b1, 4'b1100});
      if (j == 8) check("rr_idle", {busy, done, array_write_enable, a_ren, b_ren, ifc.instr_ready}, 32'd1);
      if (j > 8) check("rr_nodone", 32'(done), 32'd0);
      nxt();
      if (j == 6) rst = 1'b1;
      if (j == 7) rst = 1'b0;
    end

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      int r;
      logic [1:0] op;
      r = $urandom_range(0, 99);
      if (r < 20) op = 2'b00;
      else if (r < 25) op = 2'b01;
      else if (r < 65) op = 2'b10;
      else op = 2'b11;
      ifc.instr = {op, 14'($urandom)};
      ifc.instr_valid = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 199) == 0);
      nxt();
    end
    rst = 1'b0; ifc.instr_valid = 1'b0;
    repeat (4) nxt();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/tpu_seq_control.md
# tpu_seq_control

Parametrised sequencer for the N×N systolic-array datapath of the Mini TPU. It accepts 16-bit-style instructions over a valid/ready handshake and decodes LOAD into single-cycle operand-memory writes and STORE into array output selects. START runs a counter-driven compute phase that emits skewed per-lane read enables and element indices for memories A and B, then signals completion. Relative to the fixed 4×4 controller, this block generalises array size and data width, and adds a reset-safe FSM, an instruction handshake, busy/done status, abort, and an accumulate mode.

## Interface
- N, 4: array dimension, N ≥ 2; IDX_W = clog2(N).
- DATA_WIDTH, 8: operand width.
- INSTR_W, 16: instruction width; must be ≥ 3 + 2·IDX_W + DATA_WIDTH.
- clk  in  1  sole clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- instr  in  INSTR_W  fields: op = [INSTR_W-1:INSTR_W-2], sel = [INSTR_W-3], row = [DATA_WIDTH+2·IDX_W-1:DATA_WIDTH+IDX_W], col = [DATA_WIDTH+IDX_W-1:DATA_WIDTH], imm = [DATA_WIDTH-1:0]. Remaining bits are ignored.
- instr_valid  in  1  instruction present.
- instr_ready  out  1  instruction accepted when valid && ready.
- busy  out  1  compute phase active.
- done  out  1  one-cycle pulse on normal completion.
- array_clear  out  1  one-cycle accumulator clear at compute start.
- array_write_enable  out  1  array MAC enable; high throughout RUN.
- array_output_row, array_output_col  out  IDX_W each  STORE select.
- array_output_valid  out  1  one-cycle STORE strobe.
- mema_data_in, memb_data_in  out  DATA_WIDTH each  write data.
- mema_write_enable, memb_write_enable  out  1 each  one-cycle write strobes.
- mema_write_line, mema_write_elem, memb_write_line, memb_write_elem  out  IDX_W each  write address.
- mema_read_enable, memb_read_enable  out  N each  per-lane read enable.
- mema_read_elem, memb_read_elem  out  N·IDX_W each  lane i index in bits [i·IDX_W +: IDX_W].

## Operation
- Opcodes: 00 START, 01 STOP, 10 LOAD, 11 STORE.
- FSM states:
  - IDLE: instr_ready = 1.
  - RUN: instr_ready = 1 only when op == STOP; all other opcodes stall.
  - DONE: instr_ready = 0.
- LOAD, accepted in IDLE:
  - sel = 0: mema_write_enable = 1, mema_data_in = imm, mema_write_line = row, mema_write_elem = col.
  - sel = 1: memb write with memb_write_line = col and memb_write_elem = row (transposed).
- STORE, accepted in IDLE: array_output_row = row, array_output_col = col, array_output_valid = 1. Row/col hold their value until the next STORE.
- START, accepted in IDLE:
  - Next state RUN, cnt = 0.
  - array_clear = 1 for one cycle unless imm[0] = 1 (accumulate mode).
- RUN:
  - cnt increments by 1 each cycle; cnt is clog2(3N) bits wide.
  - When cnt == LAST = 3N−1, next state is DONE.
  - DONE lasts one cycle with done = 1, then returns to IDLE.
- Read schedule, lane i in 0..N−1, combinational from state and cnt: read_enable[i] = RUN && (i+1 ≤ cnt ≤ i+N); read_elem[i] = cnt−(i+1) while enabled, else 0. B outputs are identical to A.
- STOP:
  - In RUN: next state IDLE, done is not asserted, and all read enables drop the next cycle.
  - In IDLE: accepted as a no-op.
- Write data, write addresses and STORE row/col hold their value between strobes. Enables and strobes are low except for the defined pulses.

## Timing
- Reset: all outputs are 0 except instr_ready = 1; state IDLE, cnt = 0. Reset asserted mid-RUN forces IDLE on the next edge with no done pulse.
- Handshake accepted at edge k:
  - LOAD/STORE strobes are high during cycle k+1 only.
  - START: busy and array_write_enable are high from cycle k+1 through the end of RUN; array_clear is high during k+1.
- Read enables: lane 0 is first high at cnt = 1 (cycle k+2); lane N−1 is last high at cnt = 2N−1.
- done is high during cycle k+1+3N. For N = 4, done is at k+13 and instr_ready returns to 1 at k+14.
- Back-to-back LOAD/STORE in IDLE sustain one instruction per cycle.
- instr_valid held high with a non-STOP op during RUN waits; it is accepted in the first IDLE cycle.

## Test plan
(N = 4, DATA_WIDTH = 8, INSTR_W = 16)
- Reset, then LOAD A 0x865A: cycle k+1 has mema_write_enable = 1, data = 0x5A, line = 1, elem = 2; memb_write_enable = 0. Cycle k+2 has mema_write_enable = 0.
- LOAD B 0xACC3: memb_write_enable = 1, data = 0xC3, line = 0, elem = 3.
- START 0x0000:
  - array_clear pulses at k+1; busy is high k+1..k+12.
  - mema_read_enable is 0001 at cnt = 1 and 1111 at cnt = 4.
  - Lane 3 elem sequence is 0,1,2,3 at cnt = 4..7.
  - done pulses at k+13. A LOAD held valid during RUN sees instr_ready = 0 until k+14.
- START 0x0001 (accumulate): array_clear stays 0 and the schedule is identical to the previous scenario. A STOP 0x4000 at cnt = 5 returns the FSM to IDLE with no done pulse, and read enables are 0 the next cycle.
- STORE 0xC900: array_output_valid is high for one cycle with row = 2, col = 1; row and col hold afterwards.
- rst asserted at cnt = 6: the next cycle has all enables = 0, busy = 0, done never pulses, instr_ready = 1.
